// File: rtl/counter_pkg.sv
// counter_pkg: shared FSM state encoding and default sizing for the handshake counter.
package counter_pkg;
    typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;
    localparam int DEF_WIDTH = 8;
    localparam int DEF_STEP  = 1;
endpackage

// File: rtl/counter_step_core.sv
// counter_step_core: combinational next-count (load / step up / step down) with boundary flag.
// Boundary events wrap by default; defining COUNTER_SAT_EN clamps them instead.
module counter_step_core #(
    parameter int WIDTH = 8,
    parameter int STEP  = 1
) (
    input  logic [WIDTH-1:0] count,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             dir,
    output logic [WIDTH-1:0] next_count,
    output logic             ovf
);
    localparam logic [WIDTH:0] STEP_W = (WIDTH+1)'(STEP);
    logic [WIDTH:0] up, dn;
    logic           edge_hit;
    logic [WIDTH-1:0] stepped;
    always_comb begin
        up         = {1'b0, count} + STEP_W;
        dn         = {1'b0, count} - STEP_W;
        edge_hit   = dir ? up[WIDTH] : dn[WIDTH];
`ifdef COUNTER_SAT_EN
        stepped    = edge_hit ? (dir ? {WIDTH{1'b1}} : {WIDTH{1'b0}})
                              : (dir ? up[WIDTH-1:0] : dn[WIDTH-1:0]);
`else
        stepped    = dir ? up[WIDTH-1:0] : dn[WIDTH-1:0];
`endif
        next_count = load ? load_val : stepped;
        ovf        = !load && edge_hit;
    end
endmodule

// File: rtl/counter8_ap_hs.sv
// counter8_ap_hs: ap_ctrl_hs wrapped up/down counter, IDLE -> EXEC -> DONE, 2-cycle latency.
// Saturating boundary behaviour is selected by the COUNTER_SAT_EN macro (see counter_step_core).
module counter8_ap_hs
    import counter_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int STEP  = DEF_STEP
) (
    input  logic             ap_clk,
    input  logic             ap_rst_n,
    input  logic             ap_start,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             dir,
    output logic             ap_done,
    output logic             ap_ready,
    output logic             ap_idle,
    output logic [WIDTH-1:0] ap_return,
    output logic             ovf
);
    state_t           state, state_n;
    logic [WIDTH-1:0] count, op_val, next_count;
    logic             op_load, op_dir, ovf_r, step_ovf, capture;

    counter_step_core #(.WIDTH(WIDTH), .STEP(STEP)) u_core (
        .count     (count),
        .load      (op_load),
        .load_val  (op_val),
        .dir       (op_dir),
        .next_count(next_count),
        .ovf       (step_ovf)
    );

    // Operands are only captured when a new transaction is accepted
    always_comb begin
        capture = (state != EXEC) && ap_start;
        state_n = (state == EXEC) ? DONE : (ap_start ? EXEC : IDLE);
    end

    always_ff @(posedge ap_clk) begin
        if (!ap_rst_n) begin
            state   <= IDLE;
            count   <= '0;
            op_val  <= '0;
            op_load <= 1'b0;
            op_dir  <= 1'b0;
            ovf_r   <= 1'b0;
        end else begin
            state <= state_n;
            if (capture) begin
                op_load <= load;
                op_val  <= load_val;
                op_dir  <= dir;
            end
            if (state == EXEC) begin
                count <= next_count;
                ovf_r <= step_ovf;
            end
        end
    end

    assign ap_idle   = (state == IDLE);
    assign ap_done   = (state == DONE);
    assign ap_ready  = (state == DONE);
    assign ovf       = (state == DONE) && ovf_r;
    assign ap_return = count;
endmodule

// File: tb/tb_counter8_ap_hs.sv
// tb_counter8_ap_hs: directed-vector bench for counter8_ap_hs with hand-computed expectations.
// Expectations follow COUNTER_SAT_EN when the bench is built with it defined.
module tb_counter8_ap_hs;
    logic       ap_clk = 1'b0;
    logic       ap_rst_n = 1'b0;
    logic       ap_start = 1'b0;
    logic       load = 1'b0;
    logic [7:0] load_val = 8'h00;
    logic       dir = 1'b0;
    logic       ap_done, ap_ready, ap_idle, ovf;
    logic [7:0] ap_return;
    int         n_checks = 0;
    int         n_fail = 0;

`ifdef COUNTER_SAT_EN
    localparam logic [7:0] UP_EDGE = 8'hFF;
    localparam logic [7:0] DN_EDGE = 8'h00;
`else
    localparam logic [7:0] UP_EDGE = 8'h00;
    localparam logic [7:0] DN_EDGE = 8'hFF;
`endif

    counter8_ap_hs dut (
        .ap_clk   (ap_clk),
        .ap_rst_n (ap_rst_n),
        .ap_start (ap_start),
        .load     (load),
        .load_val (load_val),
        .dir      (dir),
        .ap_done  (ap_done),
        .ap_ready (ap_ready),
        .ap_idle  (ap_idle),
        .ap_return(ap_return),
        .ovf      (ovf)
    );

    always #5 ap_clk = ~ap_clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge ap_clk);
        #1;
    endtask

    task automatic run(input string tag, input logic ld, input logic [7:0] v, input logic d,
                       input logic [7:0] er, input logic eo);
        ap_start = 1'b1;
        load     = ld;
        load_val = v;
        dir      = d;
        step();
        ap_start = 1'b0;
        check({tag, "_exec_idle"}, 32'(ap_idle), 0);
        check({tag, "_exec_done"}, 32'(ap_done), 0);
        step();
        check({tag, "_done"}, 32'(ap_done), 1);
        check({tag, "_ready"}, 32'(ap_ready), 1);
        check({tag, "_ret"}, 32'(ap_return), 32'(er));
        check({tag, "_ovf"}, 32'(ovf), 32'(eo));
        step();
        check({tag, "_back_idle"}, 32'(ap_idle), 1);
        check({tag, "_ovf_clear"}, 32'(ovf), 0);
    endtask

    initial begin
        step();
        step();
        check("rst_idle", 32'(ap_idle), 1);
        check("rst_done", 32'(ap_done), 0);
        check("rst_ready", 32'(ap_ready), 0);
        check("rst_ret", 32'(ap_return), 0);
        check("rst_ovf", 32'(ovf), 0);
        ap_rst_n = 1'b1;
        step();
        run("first_up", 1'b0, 8'h00, 1'b1, 8'h01, 1'b0);
        run("load_fe", 1'b1, 8'hFE, 1'b1, 8'hFE, 1'b0);
        run("up_ff", 1'b0, 8'h00, 1'b1, 8'hFF, 1'b0);
        run("up_edge", 1'b0, 8'h00, 1'b1, UP_EDGE, 1'b1);
        run("load_0", 1'b1, 8'h00, 1'b1, 8'h00, 1'b0);
        run("down_edge", 1'b0, 8'h00, 1'b0, DN_EDGE, 1'b1);
        run("load_dir0", 1'b1, 8'h80, 1'b0, 8'h80, 1'b0);
        run("down_7f", 1'b0, 8'h00, 1'b0, 8'h7F, 1'b0);
        run("load_0b", 1'b1, 8'h00, 1'b0, 8'h00, 1'b0);
        // Back-to-back: start held high for ten edges
        ap_start = 1'b1;
        load     = 1'b0;
        dir      = 1'b1;
        for (int i = 1; i <= 10; i++) begin
            step();
            check("b2b_idle", 32'(ap_idle), 0);
            check("b2b_done", 32'(ap_done), 32'(i % 2 == 0));
            if (i % 2 == 0) check("b2b_ret", 32'(ap_return), 32'(i / 2));
        end
        ap_start = 1'b0;
        step();
        check("b2b_end_idle", 32'(ap_idle), 1);
        // Reset mid-transaction
        ap_start = 1'b1;
        load     = 1'b1;
        load_val = 8'h55;
        step();
        ap_start = 1'b0;
        ap_rst_n = 1'b0;
        step();
        check("abort_done", 32'(ap_done), 0);
        check("abort_idle", 32'(ap_idle), 1);
        check("abort_ret", 32'(ap_return), 0);
        ap_rst_n = 1'b1;
        step();
        check("abort_no_done", 32'(ap_done), 0);
        run("after_abort", 1'b0, 8'h00, 1'b1, 8'h01, 1'b0);
        // Operand changes during EXEC must not matter
        run("load_10", 1'b1, 8'h10, 1'b1, 8'h10, 1'b0);
        ap_start = 1'b1;
        load     = 1'b0;
        dir      = 1'b1;
        step();
        ap_start = 1'b0;
        load     = 1'b1;
        load_val = 8'hAA;
        dir      = 1'b0;
        step();
        check("hold_done", 32'(ap_done), 1);
        check("hold_ret", 32'(ap_return), 32'h11);
        check("hold_ovf", 32'(ovf), 0);
        step();
        check("hold_idle", 32'(ap_idle), 1);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/counter8_ap_hs.md
COUNTER8_AP_HS -- requirements
Module: counter8_ap_hs

Interface
REQ-001 SHALL have parameter WIDTH, default 8, counter and operand width in bits.
REQ-002 SHALL have parameter STEP, default 1, increment/decrement magnitude per transaction (1..2^WIDTH-1).
REQ-003 SHALL have port ap_clk  input  1  sole clock, all state updates on rising edge.
REQ-004 SHALL have port ap_rst_n  input  1  reset, synchronous, active-low.
REQ-005 SHALL have port ap_start  input  1  transaction request, level, ap_ctrl_hs semantics.
REQ-006 SHALL have port load  input  1  operand: 1 = load load_val instead of stepping.
REQ-007 SHALL have port load_val  input  WIDTH  operand: value to load.
REQ-008 SHALL have port dir  input  1  operand: 1 = count up, 0 = count down.
REQ-009 SHALL have port ap_done  output  1  one-cycle pulse, transaction complete.
REQ-010 SHALL have port ap_ready  output  1  one-cycle pulse, operands consumed, coincident with ap_done.
REQ-011 SHALL have port ap_idle  output  1  high only when no transaction is in flight.
REQ-012 SHALL have port ap_return  output  WIDTH  updated count, valid when ap_done=1, held until next ap_done.
REQ-013 SHALL have port ovf  output  1  pulse with ap_done when this transaction wrapped or saturated.

Function
REQ-014 SHALL implement FSM states IDLE, EXEC, DONE, one state per cycle.
REQ-015 IDLE: ap_idle=1; ap_start=1 -> capture load/load_val/dir into operand registers, go EXEC; else stay.
REQ-016 EXEC: compute next count from captured operands, register count, ap_return, ovf flag; go DONE; ap_start ignored.
REQ-017 DONE: ap_done=1, ap_ready=1; ap_start=1 -> capture new operands, go EXEC (back-to-back); else go IDLE.
REQ-018 Latency SHALL be 2 cycles: ap_start sampled in cycle N -> ap_done in cycle N+2; sustained throughput one transaction per 2 cycles.
REQ-019 load=1 SHALL set count=load_val, ovf=0, dir ignored.
REQ-020 load=0, dir=1: count+STEP in WIDTH+1-bit arithmetic; carry out -> boundary event.
REQ-021 load=0, dir=0: count-STEP; borrow -> boundary event.
REQ-022 Boundary event without saturation: result truncated to WIDTH bits (modulo wrap), ovf=1.
REQ-023 Operand inputs SHALL be sampled only on the capture edge; changes at other times have no effect.
REQ-024 ap_done, ap_ready, ovf SHALL never be high outside DONE; ap_idle SHALL never be high outside IDLE.

Reset
REQ-025 ap_rst_n=0 at a rising edge SHALL force state=IDLE, count=0, ap_return=0, operand regs=0, ovf=0, from any state including mid-transaction.
REQ-026 During/after reset outputs SHALL be ap_done=0, ap_ready=0, ap_idle=1; an aborted transaction SHALL never produce ap_done.
REQ-027 First ap_start SHALL be sampled no earlier than the first edge with ap_rst_n=1.

Configuration
REQ-028 Macro COUNTER_SAT_EN defined: boundary event SHALL clamp (up -> 2^WIDTH-1, down -> 0), ovf=1.
REQ-029 Macro COUNTER_SAT_EN undefined: boundary event SHALL wrap per REQ-022; no saturation logic present.

Structure
REQ-030 Package counter_pkg SHALL hold the FSM state enum (IDLE/EXEC/DONE) and default WIDTH/STEP constants.
REQ-031 Next-count arithmetic (load/step/wrap/saturate, ovf) SHALL be one combinational sub-module counter_step_core; FSM and registers in counter8_ap_hs.

Verification
REQ-032 Reset then ap_start pulse, load=0, dir=1 -> ap_done 2 cycles later, ap_return=1, ovf=0, ap_idle low for 2 cycles.
REQ-033 load=1, load_val=8'hFE, then two up transactions -> ap_return 8'hFF (ovf=0), then 8'h00 ovf=1 (wrap) / 8'hFF ovf=1 with COUNTER_SAT_EN.
REQ-034 From count=0, down transaction -> ap_return 8'hFF ovf=1 (wrap) / 8'h00 ovf=1 with COUNTER_SAT_EN.
REQ-035 ap_start held high 10 cycles from count=0, dir=1 -> ap_done every 2nd cycle, returns 1..5, ap_idle stays 0.
REQ-036 ap_rst_n low in EXEC after load_val=8'h55 -> no ap_done, ap_return=0, next up transaction returns 1.
REQ-037 Toggle dir/load_val in EXEC cycle -> result uses values captured at ap_start edge only.
